// File: rtl/pr_pkg.sv
// Shared types and constants for the PageRank result write unit.
package pr_pkg;

   localparam int LANES = 8;
   localparam logic [2:0] AXI_SIZE_64B = 3'b110;
   localparam int OUT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      ISSUE
   } state_t;

   typedef struct packed {
      state_t               state;
      logic [OUT_W-1:0]     outstanding;
   } dbg_t;

   // Lane 0 sits in the most significant slot of the line, matching the array layout downstream.
   function automatic logic [2:0] lane_slot(input logic [2:0] lane);
      return 3'd7 - lane;
   endfunction

endpackage

// File: rtl/pr_write_unit_if.sv
// AXI write-channel bundle (AW/W/B) between the write unit and memory.
interface pr_write_unit_if #(
   parameter int ADDR_W = 64,
   parameter int LINE_W = 512,
   parameter int ID_W   = 16
);
   // Each channel transfers on the cycle where valid and ready are both high; a raised valid
   // holds its payload stable and stays up until that transfer, independent of the other channels.
   logic [ID_W-1:0]     awid_m;
   logic [ADDR_W-1:0]   awaddr_m;
   logic [7:0]          awlen_m;
   logic [2:0]          awsize_m;
   logic                awvalid_m;
   logic                awready_m;
   logic [ID_W-1:0]     wid_m;
   logic [LINE_W-1:0]   wdata_m;
   logic [LINE_W/8-1:0] wstrb_m;
   logic                wlast_m;
   logic                wvalid_m;
   logic                wready_m;
   logic [ID_W-1:0]     bid_m;
   logic [1:0]          bresp_m;
   logic                bvalid_m;
   logic                bready_m;

   modport master (
      output awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
      output wid_m, wdata_m, wstrb_m, wlast_m, wvalid_m,
      output bready_m,
      input  awready_m, wready_m, bid_m, bresp_m, bvalid_m
   );

   modport slave (
      input  awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
      input  wid_m, wdata_m, wstrb_m, wlast_m, wvalid_m,
      input  bready_m,
      output awready_m, wready_m, bid_m, bresp_m, bvalid_m
   );
endinterface

// File: rtl/pr_write_unit_line_coalescer.sv
// Holds one open 64-byte line: merges values into lanes and accumulates byte strobes.
module line_coalescer
   import pr_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int LINE_W = 512,
   parameter int VAL_W  = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load,
   input  logic                clear,
   input  logic [ADDR_W-7:0]   line_in,
   input  logic [2:0]          lane_in,
   input  logic [VAL_W-1:0]    value_in,
   output logic [ADDR_W-1:0]   line_addr,
   output logic [LINE_W-1:0]   data,
   output logic [LINE_W/8-1:0] strb,
   output logic                full,
   output logic                full_on_load
);
   localparam int SB = VAL_W / 8;

   logic [LINE_W/8-1:0] lane_mask;
   int                  slot;

   always_comb begin
      slot      = int'(lane_slot(lane_in));
      lane_mask = '0;
      lane_mask[SB*slot +: SB] = '1;
   end

   assign full         = &strb;
   assign full_on_load = &(strb | lane_mask);

   // A repeated lane simply overwrites its value, so the last write wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_addr <= '0;
         data      <= '0;
         strb      <= '0;
      end else if (clear) begin
         line_addr <= '0;
         data      <= '0;
         strb      <= '0;
      end else if (load) begin
         line_addr                  <= {line_in, 6'b0};
         data[VAL_W*slot +: VAL_W]  <= value_in;
         strb                       <= strb | lane_mask;
      end
   end

endmodule

// File: rtl/pr_write_unit.sv
// Coalesces (index, pagerank) results into 64-byte AXI line writes and tracks their responses.
module pr_write_unit
   import pr_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int LINE_W  = 512,
   parameter int VAL_W   = 64,
   parameter int ID_W    = 16,
   parameter int WR_ID   = 3,
   parameter int MAX_OUT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_index,
   input  logic [VAL_W-1:0]  in_value,
   input  logic              flush,
   output logic              done,
   output logic              err,
   output logic [63:0]       lines_written,
   pr_write_unit_if.master   axi,
   output dbg_t              dbg
);
   state_t             state;
   logic [OUT_W-1:0]   outstanding;
   logic               flush_pend;
   logic [ADDR_W-1:0]  addr;
   logic [ADDR_W-1:0]  line_addr;
   logic [LINE_W-1:0]  line_data;
   logic [LINE_W/8-1:0] line_strb;
   logic               full, full_on_load;
   logic               hit, room, flush_req, accept, go_issue;
   logic               aw_ok, w_ok, issue_done, b_fire;
   logic               unused_bits;

   assign addr        = base_addr + ADDR_W'(in_index << 3);
   assign hit         = addr[ADDR_W-1:6] == line_addr[ADDR_W-1:6];
   assign room        = outstanding < OUT_W'(MAX_OUT);
   assign flush_req   = flush | flush_pend;
   assign unused_bits = ^{addr[2:0], axi.bid_m};

   always_comb begin
      in_ready = 1'b0;
      case (state)
         IDLE:    in_ready = reset_n;
         FILL:    in_ready = reset_n && hit && !full && !flush_req;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept     = in_valid && in_ready;
   // A full line, a flush or a result for another line all push the open line out, space permitting.
   assign go_issue   = (state == FILL) && room &&
                       (full || (accept && full_on_load) || flush_req || (in_valid && !hit));
   assign aw_ok      = !axi.awvalid_m || axi.awready_m;
   assign w_ok       = !axi.wvalid_m || axi.wready_m;
   assign issue_done = (state == ISSUE) && aw_ok && w_ok;
   assign b_fire     = axi.bvalid_m;

   line_coalescer #(
      .ADDR_W(ADDR_W),
      .LINE_W(LINE_W),
      .VAL_W (VAL_W)
   ) u_line (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (accept),
      .clear       (issue_done),
      .line_in     (addr[ADDR_W-1:6]),
      .lane_in     (addr[5:3]),
      .value_in    (in_value),
      .line_addr   (line_addr),
      .data        (line_data),
      .strb        (line_strb),
      .full        (full),
      .full_on_load(full_on_load)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         axi.awvalid_m <= 1'b0;
         axi.wvalid_m  <= 1'b0;
         outstanding   <= '0;
         lines_written <= '0;
         err           <= 1'b0;
         done          <= 1'b0;
         flush_pend    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) state <= FILL;
            FILL: if (go_issue) begin
               state         <= ISSUE;
               axi.awvalid_m <= 1'b1;
               axi.wvalid_m  <= 1'b1;
            end
            ISSUE: begin
               if (axi.awvalid_m && axi.awready_m) axi.awvalid_m <= 1'b0;
               if (axi.wvalid_m && axi.wready_m)   axi.wvalid_m  <= 1'b0;
               if (issue_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         outstanding <= outstanding + OUT_W'(issue_done) - OUT_W'(b_fire);
         if (b_fire) begin
            lines_written <= lines_written + 64'd1;
            if (axi.bresp_m != 2'b00) err <= 1'b1;
         end

         if (accept) done <= 1'b0;
         if (state == IDLE && flush_req && outstanding == '0 && !accept) begin
            done       <= 1'b1;
            flush_pend <= 1'b0;
         end else if (flush) begin
            flush_pend <= 1'b1;
         end
      end
   end

   assign axi.awid_m   = ID_W'(WR_ID);
   assign axi.awaddr_m = line_addr;
   assign axi.awlen_m  = 8'd0;
   assign axi.awsize_m = AXI_SIZE_64B;
   assign axi.wid_m    = ID_W'(WR_ID);
   assign axi.wdata_m  = line_data;
   assign axi.wstrb_m  = line_strb;
   assign axi.wlast_m  = 1'b1;
   assign axi.bready_m = 1'b1;
   assign dbg          = '{state: state, outstanding: outstanding};

endmodule
